// File: rtl/fpu_pkg.sv
// Shared definitions for the iterative floating-point divider: default field widths,
// exponent constants and the controller state encoding.
package fpu_pkg;

    localparam int unsigned EW_DEF = 8;
    localparam int unsigned MW_DEF = 23;

    localparam int unsigned EXP_BIAS = (1 << (EW_DEF - 1)) - 1;
    localparam int unsigned EXP_ONES = (1 << EW_DEF) - 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDiv  = 2'd1,
        StNorm = 2'd2,
        StDone = 2'd3
    } fsm_state_e;

    // Outcome of the operand classification done at the start of a division.
    typedef enum logic [1:0] {
        SpNone = 2'd0,
        SpZero = 2'd1,
        SpInf  = 2'd2
    } spec_e;

    function automatic int unsigned exp_bias(input int unsigned ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int unsigned exp_ones(input int unsigned ew);
        return (1 << ew) - 1;
    endfunction

endpackage

// File: rtl/fdiv_mant_iter.sv
// Radix-2 restoring mantissa divider: one quotient bit per cycle plus iteration counter.
// The first step is taken on the load edge directly from the incoming mantissas.
module fdiv_mant_iter
    import fpu_pkg::*;
#(
    parameter int unsigned MW = MW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [MW:0]   m1,
    input  logic [MW:0]   m2,
    output logic          last,
    output logic [MW+2:0] quo,
    output logic          rem_nz
);

    localparam int unsigned Q  = MW + 3;
    localparam int unsigned CW = $clog2(Q + 1);

    logic [MW+1:0] rem_q, rem_d, rem_in, diff;
    logic [MW:0]   div_q, div_d, div_in;
    logic [Q-1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ge;

    always_comb begin
        rem_in = start ? {1'b0, m1} : rem_q;
        div_in = start ? m2 : div_q;
        ge     = rem_in >= {1'b0, div_in};
        diff   = rem_in - {1'b0, div_in};
        rem_d  = rem_q;
        div_d  = div_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        if (start || (cnt_q != '0)) begin
            // Partial remainder stays below twice the divisor, so the shift never drops a one.
            rem_d = (ge ? diff : rem_in) << 1;
            div_d = div_in;
            quo_d = start ? Q'(ge) : {quo_q[Q-2:0], ge};
            cnt_d = start ? CW'(Q - 1) : cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    assign last   = (cnt_q == CW'(1));
    assign quo    = quo_q;
    assign rem_nz = (rem_q != '0);

endmodule

// File: rtl/fdiv_iter.sv
// Iterative IEEE-style divider (denormals flushed, no NaN) with valid/ready handshakes.
// Define FDIV_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int unsigned EW = EW_DEF,
    parameter int unsigned MW = MW_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] x1,
    input  logic [EW+MW:0] x2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] y,
    output logic           ovf,
    output logic           dz
);

    localparam int unsigned W   = 1 + EW + MW;
    localparam int unsigned Q   = MW + 3;
    localparam int unsigned EXW = EW + 2;
    localparam int unsigned SW  = MW + 2;

    localparam logic signed [EXW-1:0] BiasX = EXW'(exp_bias(EW));
    localparam logic signed [EXW-1:0] OnesX = EXW'(exp_ones(EW));
    localparam logic signed [EXW-1:0] ZeroX = '0;
    localparam logic [EW-1:0]         OnesE = '1;

    fsm_state_e state_q, state_d;
    logic       first_q;
    logic       accept;

    logic [EW:0] se1_q, se2_q;
    logic        x1_zero, x1_inf, x2_zero, x2_inf;

    logic                  sign_q;
    logic signed [EXW-1:0] exp_q, exp_raw;
    spec_e                 spec_q, spec_d;
    logic                  spec_dz_q, spec_dz_d;

    logic [Q-1:0] quo;
    logic         rem_nz, iter_last;

    logic [MW:0]           sig;
    logic                  guard, sticky;
    logic signed [EXW-1:0] exp_n, exp_r;
    logic [MW-1:0]         frac;
    logic [W-1:0]          y_d, y_q;
    logic                  ovf_d, ovf_q, dz_d, dz_q;

    assign accept = in_valid && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StDiv;
            StDiv:   if (iter_last) state_d = StNorm;
            StNorm:  state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            first_q <= 1'b0;
            se1_q   <= '0;
            se2_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= accept;
            if (accept) begin
                se1_q <= x1[W-1:MW];
                se2_q <= x2[W-1:MW];
            end
        end
    end

    fdiv_mant_iter #(
        .MW (MW)
    ) u_mant (
        .clk    (clk),
        .rstn   (rstn),
        .start  (accept),
        .m1     ({1'b1, x1[MW-1:0]}),
        .m2     ({1'b1, x2[MW-1:0]}),
        .last   (iter_last),
        .quo    (quo),
        .rem_nz (rem_nz)
    );

    assign x1_zero = (se1_q[EW-1:0] == '0);
    assign x1_inf  = (se1_q[EW-1:0] == OnesE);
    assign x2_zero = (se2_q[EW-1:0] == '0);
    assign x2_inf  = (se2_q[EW-1:0] == OnesE);

    // Priority: zero dividend, then zero divisor, then infinite dividend, then infinite divisor.
    always_comb begin
        spec_d    = SpNone;
        spec_dz_d = 1'b0;
        if (x1_zero) begin
            spec_d = SpZero;
        end else if (x2_zero) begin
            spec_d    = SpInf;
            spec_dz_d = 1'b1;
        end else if (x1_inf) begin
            spec_d = SpInf;
        end else if (x2_inf) begin
            spec_d = SpZero;
        end
        exp_raw = EXW'(se1_q[EW-1:0]) - EXW'(se2_q[EW-1:0]) + BiasX;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sign_q    <= 1'b0;
            exp_q     <= '0;
            spec_q    <= SpNone;
            spec_dz_q <= 1'b0;
        end else if ((state_q == StDiv) && first_q) begin
            sign_q    <= se1_q[EW] ^ se2_q[EW];
            exp_q     <= exp_raw;
            spec_q    <= spec_d;
            spec_dz_q <= spec_dz_d;
        end
    end

    // Quotient lies in (0.5, 2): the top bit selects which window holds the significand.
    always_comb begin
        if (quo[Q-1]) begin
            sig    = quo[Q-1:2];
            guard  = quo[1];
            sticky = quo[0] | rem_nz;
            exp_n  = exp_q;
        end else begin
            sig    = quo[Q-2:1];
            guard  = quo[0];
            sticky = rem_nz;
            exp_n  = exp_q - EXW'(1);
        end
    end

`ifdef FDIV_ROUND_NEAREST_EN
    logic [SW-1:0] sum;

    always_comb begin
        sum = {1'b0, sig} + SW'(guard & (sticky | sig[0]));
        if (sum[MW+1]) begin
            frac  = '0;
            exp_r = exp_n + EXW'(1);
        end else begin
            frac  = sum[MW-1:0];
            exp_r = exp_n;
        end
    end
`else
    logic unused_round;

    assign unused_round = guard ^ sticky;
    assign frac         = sig[MW-1:0];
    assign exp_r        = exp_n;
`endif

    always_comb begin
        y_d   = {sign_q, exp_r[EW-1:0], frac};
        ovf_d = 1'b0;
        dz_d  = spec_dz_q;
        unique case (spec_q)
            SpZero: y_d = {sign_q, {(W-1){1'b0}}};
            SpInf:  y_d = {sign_q, OnesE, {MW{1'b0}}};
            default: begin
                if (exp_r >= OnesX) begin
                    y_d   = {sign_q, OnesE, {MW{1'b0}}};
                    ovf_d = 1'b1;
                end else if (exp_r <= ZeroX) begin
                    y_d = {sign_q, {(W-1){1'b0}}};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_q   <= '0;
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
        end else if (state_q == StNorm) begin
            y_q   <= y_d;
            ovf_q <= ovf_d;
            dz_q  <= dz_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed table, randomized ops against an arithmetic
// model, output hold / back-pressure and mid-operation reset sequences.
module tb_fdiv_iter;

    localparam int EW = 8;
    localparam int MW = 23;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, ovf, dz;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic [31:0] y;

    int nvec = 0;
    int nfail = 0;

    fdiv_iter #(
        .EW (EW),
        .MW (MW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Quotient from plain integer division of the 24-bit significands.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] ry, output logic rovf,
                                    output logic rdz);
        logic   s;
        int     ea, eb, e;
        longint ma, mb, n, t, r, sig;
        logic   g, st;
        s    = a[31] ^ b[31];
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        rovf = 1'b0;
        rdz  = 1'b0;
        if (ea == 0) begin ry = {s, 31'd0}; return; end
        if (eb == 0) begin ry = {s, 8'hFF, 23'd0}; rdz = 1'b1; return; end
        if (ea == 255) begin ry = {s, 8'hFF, 23'd0}; return; end
        if (eb == 255) begin ry = {s, 31'd0}; return; end
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = ea - eb + 127;
        n  = ma;
        if (ma < mb) begin
            n = ma * 2;
            e = e - 1;
        end
        t   = (n << 24) / mb;
        r   = (n << 24) % mb;
        sig = t >> 1;
        g   = t[0];
        st  = (r != 0);
`ifdef FDIV_ROUND_NEAREST_EN
        if (g && (st || sig[0])) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
`else
        if (g && st) sig = sig + 0;
`endif
        if (e >= 255) begin
            ry   = {s, 8'hFF, 23'd0};
            rovf = 1'b1;
        end else if (e <= 0) begin
            ry = {s, 31'd0};
        end else begin
            ry = {s, e[7:0], sig[22:0]};
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            nvec++;
            nfail++;
            $display("FAIL accept_wait: in_ready got 0, expected 1");
        end
    endtask

    // Wait after an accept edge; lat counts edges until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            nvec++;
            nfail++;
            $display("FAIL result_wait: out_valid got 0, expected 1");
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] ry,
                         output logic rovf, output logic rdz, output int lat);
        wait_ready();
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x1 = $urandom;
        x2 = $urandom;
        wait_result(lat);
        ry   = y;
        rovf = ovf;
        rdz  = dz;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0)      v[30:23] = 8'h00;
        else if (k == 1) v[30:23] = 8'hFF;
        else if (k < 11) v[30:23] = 8'($urandom_range(90, 164));
        return v;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        dz;
    } vec_t;

    initial begin
        vec_t        tbl[10];
        logic [31:0] ry, ey, third;
        logic        rovf, rdz, eovf, edz, seen;
        int          lat;

`ifdef FDIV_ROUND_NEAREST_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        tbl[1] = '{32'h3F800000, 32'h40400000, third,        1'b0, 1'b0};
        tbl[2] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1};
        tbl[3] = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
        tbl[4] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0};
        tbl[5] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0};
        tbl[6] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0};
        tbl[7] = '{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0};
        tbl[8] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        tbl[9] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", y, 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_dz", 32'(dz), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].a, tbl[i].b, ry, rovf, rdz, lat);
            check($sformatf("tbl%0d_y", i), ry, tbl[i].y);
            check($sformatf("tbl%0d_ovf", i), 32'(rovf), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d_dz", i), 32'(rdz), 32'(tbl[i].dz));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd26);
        end

        // Randomized against the arithmetic model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = rnd_op();
            b = rnd_op();
            ref_div(a, b, ey, eovf, edz);
            do_op(a, b, ry, rovf, rdz, lat);
            check($sformatf("rnd%0d_y(%h/%h)", i, a, b), ry, ey);
            check($sformatf("rnd%0d_flags(%h/%h)", i, a, b), {30'd0, rovf, rdz},
                  {30'd0, eovf, edz});
        end

        // Back-pressure: result holds while out_ready is low, no accept in DONE
        wait_ready();
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x1 = $urandom;
            x2 = $urandom;
            @(posedge clk); #1;
            check($sformatf("hold%0d_y", i), y, third);
            check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
        end
        x1 = 32'h40C00000;
        x2 = 32'h40000000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("resume_accepted", 32'(in_ready), 32'd0);
        wait_result(lat);
        check("resume_latency", 32'(lat), 32'd26);
        check("resume_y", y, 32'h40400000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Leave dz/y set, then reset in the middle of a division
        do_op(32'hBF800000, 32'h00000000, ry, rovf, rdz, lat);
        check("predz_dz", 32'(dz), 32'd1);
        wait_ready();
        x1 = 32'h40C00000;
        x2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_y", y, 32'd0);
        check("midreset_dz", 32'(dz), 32'd0);
        check("midreset_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("postreset_no_valid", 32'(seen), 32'd0);
        check("postreset_in_ready", 32'(in_ready), 32'd1);
        do_op(32'h40C00000, 32'h40000000, ry, rovf, rdz, lat);
        check("postreset_y", ry, 32'h40400000);
        check("postreset_latency", 32'(lat), 32'd26);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
